serial_rx: RTL and testbench
============================

# serial_rx

UART receive engine for the serial port path: recovers 8N1 frames from the asynchronous RXD line using a 16× oversampling enable produced by the DDFS baud generator. Runs entirely in the system CLK domain; the baud rate enters only as a one-cycle enable. Received bytes are presented on a single-entry VALID/READY output register for the scoreboard command logic.

## Interface
- DATA_BITS, 8, data bits per frame, LSB first (5..9)
- OVERSAMPLE, 16, enable ticks per bit period (power of two, ≥8)
- CLK  in  1  system clock; all logic on rising edge
- RST_N  in  1  asynchronous, active-low reset
- TICK  in  1  oversample enable, one CLK wide, OVERSAMPLE× baud (rising edge of generator accumulator MSB)
- RXD  in  1  asynchronous serial line, idle high
- DATA  out  DATA_BITS  received byte, stable while VALID=1
- VALID  out  1  DATA holds an unconsumed byte
- READY  in  1  consumer accepts DATA when VALID&&READY
- FRAME_ERR  out  1  one-CLK pulse: stop bit sampled low
- OVERRUN  out  1  one-CLK pulse: frame completed while VALID held and READY=0

## Operation
- RXD passes through a 2-flop synchronizer (reset value 1); all decisions use synchronized value rxs.
- Tick counter tcnt, width log2(OVERSAMPLE), advances only on TICK; bit counter bcnt counts data bits.
- FSM states IDLE, START, DATA, (PARITY), STOP:
  - IDLE: on TICK with rxs=0 → START, tcnt=0.
  - START: on TICK with tcnt=OVERSAMPLE/2−1: rxs=0 → DATA, tcnt=0, bcnt=0; rxs=1 → IDLE (glitch rejected, nothing reported).
  - DATA: on TICK with tcnt=OVERSAMPLE−1 sample rxs into shift register MSB, shift right; after DATA_BITS samples → PARITY (if enabled) else STOP.
  - STOP: on TICK with tcnt=OVERSAMPLE−1: rxs=1 → frame good; rxs=0 → FRAME_ERR pulse, byte discarded. Either way → IDLE.
- Good frame delivery: if VALID=0 or READY=1 in that cycle, DATA←shift register, VALID=1; otherwise OVERRUN pulse, old DATA kept, new byte dropped.
- VALID clears on the cycle after VALID&&READY unless a good frame loads the same cycle (then stays 1 with new DATA).
- A new start bit is recognised in IDLE immediately after STOP; no extra idle time required.

## Timing
- Reset: DATA=0, VALID=0, FRAME_ERR=0, OVERRUN=0, FSM=IDLE, counters 0, synchronizer 1. Reset mid-frame abandons frame silently.
- RXD→rxs latency: 2 CLK.
- VALID/FRAME_ERR/OVERRUN assert on the CLK edge after the TICK cycle in which the stop bit is sampled.
- Stop bit sampled at mid-bit; frame complete ≈ 9.5 bit periods (10.5 with parity) after start edge.
- TICK ignored in any state where no counter update is due; no action is taken between ticks except handshake.

## Configuration
- SERIAL_RX_PARITY_EN defined: PARITY state inserted after DATA; even parity over DATA bits checked; extra output PARITY_ERR (1 bit, reset 0) pulses one CLK on mismatch at stop sampling; byte with parity error is still delivered (flag accompanies it).
- Undefined: no PARITY state, no PARITY_ERR port, frame is start+DATA_BITS+stop.

## Structure
- Package serial_pkg: FSM state enum, OVERSAMPLE-derived counter width constant, IDLE line level constant; shared with the future transmitter.
- One sub-module: serial_sync (2-flop synchronizer, parameterised reset value).

## Test plan
- 16× ticks, frame 0x55 with stop=1, READY=1 → single VALID pulse, DATA=0x55, no errors.
- RXD low for 4 ticks then high → FSM returns to IDLE, no VALID, no FRAME_ERR.
- Frame 0xA3 with stop bit 0 → FRAME_ERR one-CLK pulse, VALID stays 0.
- Back-to-back 0x12, 0x34, READY=0 → DATA=0x12 held, OVERRUN pulse at second stop; then READY=1 → VALID drops.
- RST_N asserted during bit 3 of a frame → all outputs 0; next frame 0xF0 received correctly.
- With SERIAL_RX_PARITY_EN: 0x07 with parity bit 0 → DATA=0x07, VALID=1, PARITY_ERR pulse; 0x07 with parity 1 → no PARITY_ERR.

Source files
------------

// File: rtl/serial_pkg.sv
// serial_pkg: FSM states, counter sizing and line levels shared by the serial receiver and transmitter
package serial_pkg;
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
   localparam int OVERSAMPLE_DEF = 16;
   localparam int TCNT_W = $clog2(OVERSAMPLE_DEF);
   localparam logic LINE_IDLE = 1'b1;
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/serial_sync.sv
// serial_sync: 2-flop synchronizer for an asynchronous single-bit input
module serial_sync #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);
   logic [1:0] sync_q;
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) sync_q <= {2{RST_VAL}};
      else sync_q <= {sync_q[0], d_i};
   assign q_o = sync_q[1];
endmodule

// File: rtl/serial_rx.sv
// serial_rx: oversampled 8N1 UART receiver with a single-entry VALID/READY output register
// Define SERIAL_RX_PARITY_EN to add an even-parity bit and the parity_err_o output.
module serial_rx
   import serial_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 tick_i,
   input  logic                 rxd_i,
   output logic [DATA_BITS-1:0] data_o,
   output logic                 valid_o,
   input  logic                 ready_i,
`ifdef SERIAL_RX_PARITY_EN
   output logic                 parity_err_o,
`endif
   output logic                 frame_err_o,
   output logic                 overrun_o
);
   localparam int TW = cnt_w(OVERSAMPLE);
   localparam int BW = cnt_w(DATA_BITS);
   localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
`ifdef SERIAL_RX_PARITY_EN
   localparam state_e AFTER_DATA = S_PARITY;
`else
   localparam state_e AFTER_DATA = S_STOP;
`endif
   logic rxs, last, stop_smp, good, load;
   state_e state_q, state_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
   logic valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;

   serial_sync #(.RST_VAL(LINE_IDLE)) u_sync (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .d_i   (rxd_i),
      .q_o   (rxs)
   );

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         state_q <= S_IDLE;
         tcnt_q  <= '0;
         bcnt_q  <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
         bcnt_q  <= bcnt_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end

   assign last = tcnt_q == T_LAST;

   // Counters only move on TICK; the mid-bit points are the tcnt wrap in DATA/PARITY/STOP.
   always_comb begin
      state_d = state_q;
      tcnt_d  = tcnt_q;
      bcnt_d  = bcnt_q;
      shift_d = shift_q;
      if (tick_i)
         case (state_q)
            S_IDLE: begin
               state_d = rxs ? S_IDLE : S_START;
               tcnt_d  = '0;
            end
            S_START: begin
               tcnt_d = (tcnt_q == T_HALF) ? '0 : tcnt_q + 1'b1;
               bcnt_d = '0;
               if (tcnt_q == T_HALF) state_d = rxs ? S_IDLE : S_DATA;
            end
            S_DATA: begin
               tcnt_d = tcnt_q + 1'b1;
               if (last) begin
                  shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                  bcnt_d  = bcnt_q + 1'b1;
                  if (bcnt_q == B_LAST) state_d = AFTER_DATA;
               end
            end
            default: begin
               tcnt_d = tcnt_q + 1'b1;
               if (last) state_d = (state_q == S_STOP) ? S_IDLE : S_STOP;
            end
         endcase
   end

   assign stop_smp = tick_i && state_q == S_STOP && last;
   assign good     = stop_smp && rxs;
   assign load     = good && (!valid_q || ready_i);

   always_comb begin
      data_d  = load ? shift_q : data_q;
      valid_d = load || (valid_q && !ready_i);
      ferr_d  = stop_smp && !rxs;
      ovr_d   = good && valid_q && !ready_i;
   end

`ifdef SERIAL_RX_PARITY_EN
   logic par_q, par_d, perr_q, perr_d;
   always_comb begin
      par_d  = (tick_i && state_q == S_PARITY && last) ? rxs : par_q;
      perr_d = stop_smp && (^shift_q ^ par_q);
   end
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         par_q  <= 1'b0;
         perr_q <= 1'b0;
      end else begin
         par_q  <= par_d;
         perr_q <= perr_d;
      end
   assign parity_err_o = perr_q;
`endif

   assign data_o      = data_q;
   assign valid_o     = valid_q;
   assign frame_err_o = ferr_q;
   assign overrun_o   = ovr_q;
endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: randomized self-checking bench for serial_rx against a frame-level reference model
module tb_serial_rx;
`ifdef SERIAL_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif
   logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0, rxd = 1'b1, ready = 1'b0;
   logic [7:0] data;
   logic valid, ferr, ovr;
   int n_chk = 0, n_pass = 0, fe_cyc = 0, ov_cyc = 0, vl_cyc = 0, pe_cyc = 0;
   logic [7:0] acc_q[$];
`ifdef SERIAL_RX_PARITY_EN
   logic perr;
`endif

   serial_rx dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .tick_i      (tick),
      .rxd_i       (rxd),
      .data_o      (data),
      .valid_o     (valid),
      .ready_i     (ready),
`ifdef SERIAL_RX_PARITY_EN
      .parity_err_o(perr),
`endif
      .frame_err_o (ferr),
      .overrun_o   (ovr)
   );

   always #5 clk = ~clk;

   initial forever begin
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
   end

   // Observation only: pulse widths and every byte handed over by the handshake.
   always @(negedge clk) begin
      #1;
      if (ferr) fe_cyc++;
      if (ovr) ov_cyc++;
      if (valid) vl_cyc++;
`ifdef SERIAL_RX_PARITY_EN
      if (perr) pe_cyc++;
`endif
      if (valid && ready) acc_q.push_back(data);
   end

   task automatic wait_ticks(input int n);
      repeat (n) begin
         @(posedge clk);
         while (!tick) @(posedge clk);
      end
      @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop, input bit bad_par, input int nbits);
      logic [10:0] f;
      int n;
      f = PAR_EN ? {stop, ^b ^ bad_par, b, 1'b0} : {1'b1, stop, b, 1'b0};
      n = PAR_EN ? 11 : 10;
      for (int i = 0; i < n && i < nbits; i++) begin
         rxd = f[i];
         wait_ticks(16);
      end
      rxd = 1'b1;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      #1;
      n_chk++; if (data !== 8'h00) $display("FAIL reset_data: got %h want 00", data); else n_pass++;
      n_chk++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else n_pass++;
      n_chk++; if (ferr !== 1'b0) $display("FAIL reset_ferr: got %b want 0", ferr); else n_pass++;
      n_chk++; if (ovr !== 1'b0) $display("FAIL reset_ovr: got %b want 0", ovr); else n_pass++;
      rst_n = 1'b1;
      wait_ticks(4);
   endtask

   task automatic test_good_frame;
      int a, f, o, v;
      ready = 1'b1;
      a = acc_q.size(); f = fe_cyc; o = ov_cyc; v = vl_cyc;
      send_frame(8'h55, 1'b1, 1'b0, 99);
      wait_ticks(20);
      n_chk++; if (acc_q.size() - a !== 1) $display("FAIL good_count: got %0d want 1", acc_q.size() - a); else n_pass++;
      n_chk++; if (acc_q[a] !== 8'h55) $display("FAIL good_data: got %h want 55", acc_q[a]); else n_pass++;
      n_chk++; if (vl_cyc - v !== 1) $display("FAIL good_valid_width: got %0d want 1", vl_cyc - v); else n_pass++;
      n_chk++; if (fe_cyc - f !== 0) $display("FAIL good_ferr: got %0d want 0", fe_cyc - f); else n_pass++;
      n_chk++; if (ov_cyc - o !== 0) $display("FAIL good_ovr: got %0d want 0", ov_cyc - o); else n_pass++;
   endtask

   task automatic test_glitch;
      int a, f;
      a = acc_q.size(); f = fe_cyc;
      rxd = 1'b0;
      wait_ticks(4);
      rxd = 1'b1;
      wait_ticks(40);
      n_chk++; if (acc_q.size() - a !== 0) $display("FAIL glitch_count: got %0d want 0", acc_q.size() - a); else n_pass++;
      n_chk++; if (fe_cyc - f !== 0) $display("FAIL glitch_ferr: got %0d want 0", fe_cyc - f); else n_pass++;
      n_chk++; if (valid !== 1'b0) $display("FAIL glitch_valid: got %b want 0", valid); else n_pass++;
   endtask

   task automatic test_frame_err;
      int a, f, v;
      a = acc_q.size(); f = fe_cyc; v = vl_cyc;
      send_frame(8'hA3, 1'b0, 1'b0, 99);
      wait_ticks(30);
      n_chk++; if (fe_cyc - f !== 1) $display("FAIL ferr_pulse: got %0d cycles want 1", fe_cyc - f); else n_pass++;
      n_chk++; if (acc_q.size() - a !== 0) $display("FAIL ferr_count: got %0d want 0", acc_q.size() - a); else n_pass++;
      n_chk++; if (vl_cyc - v !== 0) $display("FAIL ferr_valid: got %0d cycles want 0", vl_cyc - v); else n_pass++;
   endtask

   task automatic test_back_to_back;
      int a, o;
      ready = 1'b0;
      a = acc_q.size(); o = ov_cyc;
      send_frame(8'h12, 1'b1, 1'b0, 99);
      send_frame(8'h34, 1'b1, 1'b0, 99);
      wait_ticks(20);
      n_chk++; if (valid !== 1'b1) $display("FAIL b2b_valid_held: got %b want 1", valid); else n_pass++;
      n_chk++; if (data !== 8'h12) $display("FAIL b2b_data_held: got %h want 12", data); else n_pass++;
      n_chk++; if (ov_cyc - o !== 1) $display("FAIL b2b_overrun: got %0d cycles want 1", ov_cyc - o); else n_pass++;
      ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #2;
      n_chk++; if (valid !== 1'b0) $display("FAIL b2b_valid_drop: got %b want 0", valid); else n_pass++;
      n_chk++; if (acc_q.size() - a !== 1) $display("FAIL b2b_count: got %0d want 1", acc_q.size() - a); else n_pass++;
      n_chk++; if (acc_q[a] !== 8'h12) $display("FAIL b2b_accepted: got %h want 12", acc_q[a]); else n_pass++;
   endtask

   task automatic test_reset_mid;
      int a, f;
      ready = 1'b0;
      send_frame(8'h81, 1'b1, 1'b0, 99);
      wait_ticks(4);
      n_chk++; if (valid !== 1'b1) $display("FAIL rstmid_pre_valid: got %b want 1", valid); else n_pass++;
      send_frame(8'hCF, 1'b1, 1'b0, 4);
      wait_ticks(8);
      rst_n = 1'b0;
      #1;
      n_chk++; if (valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", valid); else n_pass++;
      n_chk++; if (data !== 8'h00) $display("FAIL rstmid_data: got %h want 00", data); else n_pass++;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      ready = 1'b1;
      wait_ticks(32);
      a = acc_q.size(); f = fe_cyc;
      send_frame(8'hF0, 1'b1, 1'b0, 99);
      wait_ticks(20);
      n_chk++; if (acc_q.size() - a !== 1) $display("FAIL rstmid_count: got %0d want 1", acc_q.size() - a); else n_pass++;
      n_chk++; if (acc_q[a] !== 8'hF0) $display("FAIL rstmid_data_after: got %h want f0", acc_q[a]); else n_pass++;
      n_chk++; if (fe_cyc - f !== 0) $display("FAIL rstmid_ferr: got %0d want 0", fe_cyc - f); else n_pass++;
   endtask

   task automatic test_random;
      logic [7:0] exp_q[$];
      logic [7:0] b;
      int a, f, o, fe_exp;
      bit bad;
      ready = 1'b1;
      fe_exp = 0;
      a = acc_q.size(); f = fe_cyc; o = ov_cyc;
      for (int k = 0; k < 16; k++) begin
         b = 8'($urandom);
         bad = ($urandom_range(0, 4) == 0);
         send_frame(b, !bad, 1'b0, 99);
         if (bad) fe_exp++;
         else exp_q.push_back(b);
         wait_ticks(bad ? 16 + int'($urandom_range(0, 8)) : int'($urandom_range(0, 8)));
      end
      wait_ticks(20);
      n_chk++; if (acc_q.size() - a !== exp_q.size()) $display("FAIL rand_count: got %0d want %0d", acc_q.size() - a, exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size(); i++) begin
         n_chk++; if (acc_q[a+i] !== exp_q[i]) $display("FAIL rand_data[%0d]: got %h want %h", i, acc_q[a+i], exp_q[i]); else n_pass++;
      end
      n_chk++; if (fe_cyc - f !== fe_exp) $display("FAIL rand_ferr: got %0d want %0d", fe_cyc - f, fe_exp); else n_pass++;
      n_chk++; if (ov_cyc - o !== 0) $display("FAIL rand_ovr: got %0d want 0", ov_cyc - o); else n_pass++;
   endtask

   task automatic test_parity;
      int a, p;
      ready = 1'b1;
      a = acc_q.size(); p = pe_cyc;
      send_frame(8'h07, 1'b1, 1'b1, 99);
      wait_ticks(20);
      n_chk++; if (pe_cyc - p !== 1) $display("FAIL par_bad_pulse: got %0d want 1", pe_cyc - p); else n_pass++;
      n_chk++; if (acc_q[a] !== 8'h07) $display("FAIL par_bad_data: got %h want 07", acc_q[a]); else n_pass++;
      p = pe_cyc;
      send_frame(8'h07, 1'b1, 1'b0, 99);
      wait_ticks(20);
      n_chk++; if (pe_cyc - p !== 0) $display("FAIL par_good_pulse: got %0d want 0", pe_cyc - p); else n_pass++;
      n_chk++; if (acc_q.size() - a !== 2) $display("FAIL par_count: got %0d want 2", acc_q.size() - a); else n_pass++;
   endtask

   initial begin
      test_reset;
      test_good_frame;
      test_glitch;
      test_frame_err;
      test_back_to_back;
      test_reset_mid;
      test_random;
      if (PAR_EN) test_parity;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
